// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the MEM-stage pipeline and a
// debug/loader requester; one access in flight at a time, round-robin on conflict.
module data_mem_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_data_read,
    input  logic              ex_data_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_result,
    output logic              ex_stall,
    output logic [DATA_W-1:0] ex_rdata,
    output logic              ex_rdata_valid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              owner_q;      // 1 = debug owns the current access
    logic              last_dbg_q;   // 1 = debug was granted most recently
    logic              we_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] ex_rdata_q;
    logic              ex_rdata_valid_q;
    logic              dbg_gnt_q;
    logic              dbg_done_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    logic              pipe_req_s;
    logic              owner_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    // Owner selection for a grant taken in IDLE; a simultaneous read+write is a write.
    always_comb begin
        pipe_req_s = ex_data_read | ex_data_write;
        if (pipe_req_s && dbg_req) begin
            owner_d = ~last_dbg_q;
        end else if (dbg_req) begin
            owner_d = 1'b1;
        end else begin
            owner_d = 1'b0;
        end
        if (owner_d) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
        end else begin
            we_d    = ex_data_write;
            addr_d  = ex_addr;
            wdata_d = ex_result;
        end
    end

    // Access sequencer with all memory and response outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= S_IDLE;
            cnt_q            <= 4'd0;
            owner_q          <= 1'b0;
            last_dbg_q       <= 1'b1;
            we_q             <= 1'b0;
            mem_en_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            ex_rdata_q       <= '0;
            ex_rdata_valid_q <= 1'b0;
            dbg_gnt_q        <= 1'b0;
            dbg_done_q       <= 1'b0;
            dbg_rdata_q      <= '0;
        end else begin
            mem_en_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            dbg_gnt_q        <= 1'b0;
            dbg_done_q       <= 1'b0;
            ex_rdata_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pipe_req_s || dbg_req) begin
                        state_q     <= S_ISSUE;
                        owner_q     <= owner_d;
                        last_dbg_q  <= owner_d;
                        we_q        <= we_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= we_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        dbg_gnt_q   <= owner_d;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        state_q    <= S_RESP;
                        dbg_done_q <= owner_q;
                    end else begin
                        state_q <= S_WAIT;
                        cnt_q   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    // Read data is valid in the final WAIT cycle.
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_RESP;
                        cnt_q   <= 4'd0;
                        if (owner_q) begin
                            dbg_rdata_q <= mem_rdata;
                            dbg_done_q  <= 1'b1;
                        end else begin
                            ex_rdata_q       <= mem_rdata;
                            ex_rdata_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Low in the pipeline's completion cycle so the pipeline advances on that edge.
    assign ex_stall       = pipe_req_s & ~((state_q == S_RESP) & ~owner_q) & ~RST;
    assign ex_rdata       = ex_rdata_q;
    assign ex_rdata_valid = ex_rdata_valid_q;
    assign dbg_gnt        = dbg_gnt_q;
    assign dbg_done       = dbg_done_q;
    assign dbg_rdata      = dbg_rdata_q;
    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Sequences the single-port data memory for the MEM stage and shares that port with a debug/loader requester.
- Pipeline side: consumes the data_read, data_write, addr and result outputs of the execution register.
- Memory side: drives the data memory with registered controls and handles fixed read latency.
- Stalls the pipeline registers until each pipeline access completes.
- Arbitrates pipeline vs debug round-robin when both request in the same cycle.

Parameters:
DATA_W, 16, data word width
ADDR_W, 8, data memory address width
WAIT_CYCLES, 2, cycles from mem_en (read) to valid mem_rdata; legal range 1..15

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  synchronous active-high reset
ex_data_read  in  1  pipeline read request (held while ex_stall)
ex_data_write  in  1  pipeline write request (held while ex_stall)
ex_addr  in  ADDR_W  pipeline access address
ex_result  in  DATA_W  pipeline write data
ex_stall  out  1  freeze pipeline registers (combinational)
ex_rdata  out  DATA_W  pipeline read data
ex_rdata_valid  out  1  one-cycle pulse, ex_rdata valid
dbg_req  in  1  debug request, held until dbg_done
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  one-cycle pulse, debug access issued
dbg_done  out  1  one-cycle pulse, debug access complete
dbg_rdata  out  DATA_W  debug read data, valid with dbg_done
mem_en  out  1  memory access strobe (registered)
mem_we  out  1  memory write enable (registered)
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid WAIT_CYCLES after mem_en

Behaviour:
- pipe_req = ex_data_read | ex_data_write. If both are high, treat as a write only: no ex_rdata_valid.
- FSM states: IDLE, ISSUE, WAIT, RESP. Owner register records pipe or dbg.
- IDLE:
  - With any request, select an owner and latch addr, we and wdata from that owner. Later input changes are ignored.
  - Go to ISSUE.
  - With no request, stay in IDLE.
- Arbitration when both request: grant the side not granted last (rr bit).
  - Single request: grant it.
  - rr resets so that the pipeline wins the first conflict.
  - rr updates on every grant.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr and mem_wdata latched.
  - dbg_gnt=1 if owner is dbg.
  - Write goes to RESP. Read goes to WAIT with counter=WAIT_CYCLES.
- WAIT: lasts exactly WAIT_CYCLES cycles. mem_en=0.
  - On the last WAIT cycle, capture mem_rdata into ex_rdata or dbg_rdata according to owner.
  - Go to RESP.
- RESP (1 cycle):
  - Owner pipe: ex_rdata_valid=1 if read.
  - Owner dbg: dbg_done=1.
  - Go to IDLE. RESP never grants, so a held request is never double-issued.
- ex_stall = pipe_req & ~(state==RESP & owner==pipe) & ~RST. It is low in the completion cycle so the pipeline advances on that edge.
- Latency, request first seen in an idle IDLE cycle 0:
  - Write: mem_en in cycle 1, RESP in cycle 2, ex_stall high cycles 0–1.
  - Read: mem_en in cycle 1, capture at cycle 1+WAIT_CYCLES, RESP in cycle 2+WAIT_CYCLES.
- Losing or late requests: wait in IDLE after the current RESP. ex_stall stays high throughout.
- ex_rdata and dbg_rdata hold their value until the next capture.
- dbg_req deasserted mid-access: the access still completes and dbg_done still pulses.
- RST (any state, including WAIT):
  - Next state IDLE, counter=0, rr set to pipeline priority.
  - All outputs reset to 0: mem_*, ex_rdata, ex_rdata_valid, dbg_gnt, dbg_done, dbg_rdata.
  - In-flight access discarded, no completion pulse. ex_stall forced to 0 while RST is high.

Test Plan:
- Pipe write, ex_addr=0x12, ex_result=0xBEEF at cycle 0 -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x12, mem_wdata=0xBEEF; ex_stall=1 in cycles 0–1, 0 in cycle 2.
- Pipe read 0x34, memory model returns 0x1234 (WAIT_CYCLES=2) -> mem_en=1, mem_we=0 at cycle 1; cycle 4: ex_rdata_valid=1, ex_rdata=0x1234; ex_stall high in cycles 0–3.
- Pipe read 0x01 and dbg write 0x02/0x5A5A together after reset -> pipe issued first, dbg_gnt next; repeated conflict -> dbg issued first (round-robin).
- Pipe request held through completion, then new address 0x20 -> exactly one mem_en per request, no duplicate issue of 0x12.
- RST asserted during WAIT of a pipe read -> next cycle all outputs 0, state IDLE, no ex_rdata_valid; re-presented read completes with correct data.
- ex_data_read=1 and ex_data_write=1, addr 0x40, data 0x00FF -> write issued with mem_we=1, no ex_rdata_valid pulse.
